tone_meter: RTL

Measures the frequency of an incoming square-wave audio signal, the receive-side counterpart of the sweeping tone generator that drives the speaker pin. The block synchronises the asynchronous input and counts `clk` cycles between successive rising edges. It reports full period and high time with a one-cycle valid strobe, flags a stable tone with `locked`, and returns to idle when the input goes silent. It sits between a board input pin (loopback from the speaker or a comparator output) and any display or logger logic.

---
 rtl/tone_meter.sv | 98 +++++++++
 1 files changed

// File: rtl/tone_meter.sv
// Square-wave frequency meter: synchronises audio_in, counts clk cycles between
// rising edges, and reports period, high time, lock status and silence timeout.
module tone_meter #(
    parameter int CNT_W      = 20,
    parameter int MIN_PERIOD = 64,
    parameter int TOL        = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             audio_in,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             period_valid,
    output logic             locked,
    output logic             timeout
);

    typedef enum logic {IDLE, MEASURE} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] MIN_P   = CNT_W'(MIN_PERIOD);
    localparam logic [CNT_W-1:0] TOL_C   = CNT_W'(TOL);

    state_t           state;
    logic             s1, s2, prev;
    logic [CNT_W-1:0] cnt, hcap, diff;
    logic             rise, fall;

    assign rise = s2 & ~prev;
    assign fall = ~s2 & prev;
    assign diff = (cnt >= period) ? (cnt - period) : (period - cnt);

    // Timeout is checked first so a rise landing on a saturated count clears outputs
    // but still restarts the measurement.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            s1           <= 1'b0;
            s2           <= 1'b0;
            prev         <= 1'b0;
            cnt          <= '0;
            hcap         <= '0;
            period       <= '0;
            high_time    <= '0;
            period_valid <= 1'b0;
            locked       <= 1'b0;
            timeout      <= 1'b0;
        end else begin
            s1           <= audio_in;
            s2           <= s1;
            prev         <= s2;
            period_valid <= 1'b0;
            timeout      <= 1'b0;
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (rise) begin
                        state <= MEASURE;
                        cnt   <= CNT_W'(1);
                        hcap  <= '0;
                    end
                end
                MEASURE: begin
                    if (cnt == CNT_MAX) begin
                        timeout   <= 1'b1;
                        period    <= '0;
                        high_time <= '0;
                        locked    <= 1'b0;
                        if (rise) begin
                            cnt  <= CNT_W'(1);
                            hcap <= '0;
                        end else begin
                            state <= IDLE;
                            cnt   <= '0;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                        if (fall) begin
                            hcap <= cnt;
                        end
                        if (rise && (cnt >= MIN_P)) begin
                            period       <= cnt;
                            high_time    <= hcap;
                            period_valid <= 1'b1;
                            locked       <= (diff <= TOL_C);
                            cnt          <= CNT_W'(1);
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule
